// File: rtl/param_syn_counter_pkg.sv
// Shared constants and helpers for the synchronous-counter family.
// Direction/mode encodings plus the load clamp used by the next-state logic.
package cnt_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Out-of-range load values pin to the top of the count range.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] m);
        return (val < m) ? val : (m - 32'd1);
    endfunction

endpackage

// File: rtl/param_syn_counter_next.sv
// Combinational next-count and boundary-event logic for param_syn_counter.
// Priority: clr > load > en; the boundary event only fires on a counting step.
module cnt_next_logic
    import cnt_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MOD       = 2**WIDTH,
    parameter int SATURATE  = CNT_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] next_count,
    output logic             evt
);

    // WIDTH+1-bit compare keeps MOD == 2**WIDTH free of special cases.
    localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);

    logic at_top, at_bot;

    assign at_top = ({1'b0, count} == TOP_X);
    assign at_bot = (count == '0);

    always_comb begin
        next_count = count;
        evt        = 1'b0;
        if (clr) begin
            next_count = WIDTH'(RESET_VAL);
        end else if (load) begin
            next_count = WIDTH'(clamp_load(32'(load_val), 32'(MOD)));
        end else if (en) begin
            if (up == CNT_UP) begin
                if (at_top) begin
                    evt        = 1'b1;
                    next_count = (SATURATE == CNT_SAT) ? count : '0;
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    evt        = 1'b1;
                    next_count = (SATURATE == CNT_SAT) ? count : TOP;
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/param_syn_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate mode
// and terminal-count / wrap / sticky-overflow status.
module param_syn_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MOD       = 2**WIDTH,
    parameter int SATURATE  = CNT_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] next_count;
    logic             evt;

    cnt_next_logic #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE),
        .RESET_VAL(RESET_VAL)
    ) u_next (
        .count     (count),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .clr       (clr),
        .next_count(next_count),
        .evt       (evt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= WIDTH'(RESET_VAL);
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= evt;
            if (clr)
                ovf_sticky <= 1'b0;
            else if (evt)
                ovf_sticky <= 1'b1;
        end
    end

    assign tc = en & ((up & (count == TOP)) | (~up & (count == '0)));

endmodule

// File: doc/param_syn_counter.md
Name: param_syn_counter

Overview:
- Parametrised successor to the team's fixed 4-bit synchronous binary up-counter.
- Adds configurable width and modulus, up/down direction, count enable, parallel load, synchronous clear, and wrap or saturate mode.
- Adds terminal-count and wrap/overflow status outputs.
- Used as the general-purpose timing/event counter in the synchronous-counter family.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- MOD, 2**WIDTH, modulus; count range is 0..MOD-1 (2 <= MOD <= 2**WIDTH).
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
- RESET_VAL, 0, value loaded on reset and on clr (must be < MOD).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  count enable; advances the count by one step when high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when load is high.
- clr  input  1  synchronous clear to RESET_VAL; also clears ovf_sticky.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & ((up & count==MOD-1) | (~up & count==0)).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a boundary crossing or saturation hit.
- ovf_sticky  output  1  registered; set by any boundary event, held until clr or reset.

Behaviour:
- Reset (reset==0 at a clk edge):
  - count=RESET_VAL, wrap=0, ovf_sticky=0.
  - Overrides every other input.
  - Mid-count reset takes effect at that edge; no partial update.
- Priority per edge: reset > clr > load > en. Lower-priority inputs are ignored in the same cycle.
- clr:
  - count=RESET_VAL, wrap=0, ovf_sticky=0.
- load:
  - count=load_val when load_val < MOD; otherwise count=MOD-1 (clamp).
  - wrap=0; ovf_sticky unchanged.
- en=1, no higher-priority input:
  - up=1, count<MOD-1: count+1.
  - up=1, count==MOD-1: next count=0 if SATURATE=0, or held at MOD-1 if SATURATE=1. In both cases the event sets wrap=1 next cycle and sets ovf_sticky.
  - up=0, count>0: count-1.
  - up=0, count==0: next count=MOD-1 if SATURATE=0, or held at 0 if SATURATE=1. In both cases the event sets wrap and ovf_sticky.
- en=0: count held, wrap=0.
- Latency:
  - count reflects an input one edge after it is sampled.
  - There is no extra output register stage; count is the state register itself.
- wrap is high for exactly one cycle per boundary event. With SATURATE=1 and en held at a boundary, wrap stays high every cycle.
- Direction change: up may change on any cycle and takes effect immediately; there is no dead cycle.
- Arithmetic:
  - Unsigned, modulo MOD.
  - The next-value compare uses WIDTH+1 bits, so MOD=2**WIDTH needs no special case.
- No X on outputs after the first reset edge. Outputs before the first reset are undefined.

Decomposition:
- Package cnt_pkg holds:
  - CNT_UP=1'b1 and CNT_DOWN=1'b0 direction constants.
  - CNT_WRAP=0 and CNT_SAT=1 mode constants.
  - A function clamp_load(val, MOD).
- One sub-module, cnt_next_logic: combinational.
  - Inputs: count, en, up, load, load_val, clr.
  - Outputs: next_count and the boundary-event flag.
  - Parametrised by WIDTH, MOD, SATURATE.
- The top module keeps the registers, the reset and the status flags.

Test Plan (WIDTH=4, MOD=10, RESET_VAL=0 unless stated):
- Reset low for 2 cycles with en=1 up=1, then release → count=0, wrap=0, ovf_sticky=0; count then steps 1,2,…,9,0.
- At 9→0, tc=1 while count=9 and wrap=1 for the single cycle after. ovf_sticky=1 and stays set.
- SATURATE=1, up=0 from count=2 for 4 cycles → count 1,0,0,0; wrap=1 on both cycles after the held-at-0 events; tc=1 while count=0.
- load=1 load_val=7 together with en=1 → count=7 (load beats en).
- load_val=13 → count=9 (clamped).
- clr=1 with load=1 → count=0, ovf_sticky cleared.
- Mid-count: count=5, drive reset=0 for one edge with en=1 load=1 → count=0, wrap=0.
- Next edge with reset=1 en=1 up=0 → count=9 (wrap down), wrap=1 the cycle after.
- WIDTH=8, MOD=256 → 255+1 gives 0 with wrap; en=0 for 10 cycles holds count with no wrap pulse.
